// File: rtl/four_ask_demod_if.sv
// Sample-in / symbol-out bundle of the 4-ASK demodulator.
// Latency: n/a (signal bundle only).
// Backpressure: none; one sample per clock, outputs are free-running registers.
// Ports: sample/resync flow from the ADC side (master) into the demodulator (slave);
//        message/msg_valid/symbol/sym_valid/level flow back out to the sink.
interface four_ask_demod_if;
    logic [7:0] sample;
    logic       resync;
    logic       message;
    logic       msg_valid;
    logic [1:0] symbol;
    logic       sym_valid;
    logic [7:0] level;

    modport master (
        output sample, resync,
        input  message, msg_valid, symbol, sym_valid, level
    );

    modport slave (
        input  sample, resync,
        output message, msg_valid, symbol, sym_valid, level
    );
endinterface

// File: rtl/four_ask_demod.sv
// 4-ASK demodulator: integrates |sample-128| over a window per symbol, slices to 2 bits, reserialises MSB first.
// Latency: decision registered at the symbol wrap; a symbol received in period N is on message during period N+1.
// Backpressure: none; consumes one sample every clock, resync restarts symbol timing.
// Ports: clk (rising edge), rst (async active-low), bus (slave side of four_ask_demod_if).
module four_ask_demod #(
    parameter int SYM_CYCLES = 50000,
    parameter int WIN_LOG2   = 14,
    parameter int WIN_START  = 16808,
    parameter int TH1        = 13,
    parameter int TH2        = 40,
    parameter int TH3        = 67
) (
    input  logic            clk,
    input  logic            rst,
    four_ask_demod_if.slave bus
);
    localparam int CW = $clog2(SYM_CYCLES);
    localparam int AW = WIN_LOG2 + 8;
    localparam logic [CW-1:0] CNT_LAST     = CW'(SYM_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF_M1  = CW'(SYM_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_WIN_OPEN = CW'(WIN_START);
    localparam logic [CW-1:0] CNT_WIN_LAST = CW'(WIN_START + (1 << WIN_LOG2) - 1);

    typedef enum logic [1:0] {ST_WAIT, ST_INTEG, ST_DECIDE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   sym_cnt;
    logic [AW-1:0]   acc;
    logic [7:0]      dev;
    logic [7:0]      mean;
    logic [1:0]      sym_dec;
    logic            decide_now;

    logic            message_q;
    logic            msg_valid_q;
    logic [1:0]      symbol_q;
    logic            sym_valid_q;
    logic [7:0]      level_q;

    // |sample-128|; 128-0 = 128 still fits in 8 bits
    assign dev  = bus.sample[7] ? {1'b0, bus.sample[6:0]} : (8'd128 - bus.sample);
    // window length is a power of two, so the mean is just the upper bits
    assign mean = acc[AW-1:WIN_LOG2];

    // resync at the decision point suppresses the decision
    assign decide_now = (state == ST_DECIDE) && (sym_cnt == CNT_LAST) && !bus.resync;

    always_comb begin
        sym_dec = 2'b00;
        if (mean >= 8'(TH3))      sym_dec = 2'b11;
        else if (mean >= 8'(TH2)) sym_dec = 2'b10;
        else if (mean >= 8'(TH1)) sym_dec = 2'b01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   sym_cnt <= '0;
        else if (bus.resync)        sym_cnt <= '0;
        else if (sym_cnt == CNT_LAST) sym_cnt <= '0;
        else                        sym_cnt <= sym_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_WAIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.resync) begin
            state_nxt = ST_WAIT;
        end else begin
            case (state)
                ST_WAIT:   if (sym_cnt == CNT_WIN_OPEN) state_nxt = ST_INTEG;
                ST_INTEG:  if (sym_cnt == CNT_WIN_LAST) state_nxt = ST_DECIDE;
                ST_DECIDE: if (sym_cnt == CNT_LAST)     state_nxt = ST_WAIT;
                default:   state_nxt = ST_WAIT;
            endcase
        end
    end

    // window-open sample loads rather than adds, so no clear is needed between symbols
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                             acc <= '0;
        else if (bus.resync)                                  acc <= '0;
        else if (state == ST_WAIT && sym_cnt == CNT_WIN_OPEN) acc <= AW'(dev);
        else if (state == ST_INTEG)                           acc <= acc + AW'(dev);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_valid_q <= 1'b0;
            symbol_q    <= 2'b00;
            level_q     <= 8'd0;
            msg_valid_q <= 1'b0;
        end else begin
            sym_valid_q <= decide_now;
            if (decide_now) begin
                symbol_q    <= sym_dec;
                level_q     <= mean;
                msg_valid_q <= 1'b1;
            end
        end
    end

    // Serialiser tracks the symbol register: at the wrap it takes the symbol
    // being registered on that same edge, so message and symbol stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         message_q <= 1'b0;
        else if (bus.resync)              message_q <= symbol_q[1];
        else if (sym_cnt == CNT_LAST)     message_q <= decide_now ? sym_dec[1] : symbol_q[1];
        else if (sym_cnt == CNT_HALF_M1)  message_q <= symbol_q[0];
    end

    assign bus.message   = message_q;
    assign bus.msg_valid = msg_valid_q;
    assign bus.symbol    = symbol_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_four_ask_demod.sv
// Bench for four_ask_demod with a shortened symbol (64 clocks, 32-sample window at 16).
// Reference: per-period window sum divided by the window length, sliced by thresholds;
// message expected as the current symbol's MSB in the first half-period, LSB in the second.
module tb_four_ask_demod;
    localparam int SC = 64;
    localparam int WL = 5;
    localparam int WS = 16;
    localparam int WN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    four_ask_demod_if bus ();

    four_ask_demod #(
        .SYM_CYCLES(SC), .WIN_LOG2(WL), .WIN_START(WS),
        .TH1(13), .TH2(40), .TH3(67)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference state
    int         m_cnt;
    int         m_sum;
    logic [1:0] e_sym;
    logic [7:0] e_lvl;
    logic       e_sv;
    logic       e_mv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] slice(input int mean);
        if (mean >= 67) return 2'b11;
        if (mean >= 40) return 2'b10;
        if (mean >= 13) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_sum = 0;
        e_sym = 2'b00; e_lvl = 8'd0; e_sv = 1'b0; e_mv = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_message"},   32'(bus.message),   32'd0);
        chk({tag, "_msg_valid"}, 32'(bus.msg_valid), 32'd0);
        chk({tag, "_symbol"},    32'(bus.symbol),    32'd0);
        chk({tag, "_sym_valid"}, 32'(bus.sym_valid), 32'd0);
        chk({tag, "_level"},     32'(bus.level),     32'd0);
    endtask

    // one clock: drive inputs, advance the reference, compare all outputs after the edge
    task automatic cyc(input int s, input bit r);
        int   dev;
        logic exp_msg;
        dev = (s >= 128) ? s - 128 : 128 - s;
        bus.sample = 8'(s);
        bus.resync = r;
        e_sv = 1'b0;
        if (r) begin
            m_cnt = 0;
            m_sum = 0;
        end else begin
            if (m_cnt >= WS && m_cnt < WS + WN) m_sum += dev;
            if (m_cnt == SC - 1) begin
                e_lvl = 8'(m_sum / WN);
                e_sym = slice(m_sum / WN);
                e_sv  = 1'b1;
                e_mv  = 1'b1;
                m_sum = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        bus.resync = 1'b0;
        exp_msg = (m_cnt < SC / 2) ? e_sym[1] : e_sym[0];
        chk("sym_valid", 32'(bus.sym_valid), 32'(e_sv));
        chk("symbol",    32'(bus.symbol),    32'(e_sym));
        chk("level",     32'(bus.level),     32'(e_lvl));
        chk("msg_valid", 32'(bus.msg_valid), 32'(e_mv));
        chk("message",   32'(bus.message),   32'(exp_msg));
    endtask

    // one full period of a constant sample, then compare against hand-derived values
    task automatic sym_const(input int v, input int lvl, input int sym);
        for (int i = 0; i < SC; i++) cyc(v, 1'b0);
        chk("tbl_level",  32'(bus.level),     32'(lvl));
        chk("tbl_symbol", 32'(bus.symbol),    32'(sym));
        chk("tbl_pulse",  32'(bus.sym_valid), 32'd1);
    endtask

    initial begin
        int amp;
        int s;
        int r_at;
        bus.sample = 8'd128;
        bus.resync = 1'b0;
        model_reset();

        // reset held for 3 clocks
        repeat (3) @(posedge clk);
        #1;
        check_zero("in_rst");
        rst = 1'b1;
        #1;
        check_zero("post_rst");

        // four levels, one per symbol; first pulse lands 64 clocks after release
        sym_const(128, 0, 0);
        sym_const(141, 13, 1);
        sym_const(168, 40, 2);
        sym_const(200, 72, 3);

        // threshold and range boundaries
        sym_const(140, 12, 0);
        sym_const(195, 67, 3);
        sym_const(0, 128, 3);
        sym_const(255, 127, 3);

        // alternating 128+/-54 in the window, 255 glitches outside it
        for (int i = 0; i < SC; i++) begin
            if (i < WS || i >= WS + WN) s = 255;
            else                        s = (i % 2) ? 182 : 74;
            cyc(s, 1'b0);
        end
        chk("alt_level",  32'(bus.level),  32'd54);
        chk("alt_symbol", 32'(bus.symbol), 32'd2);

        // resync mid-window: decision suppressed, then 64 clocks later
        sym_const(141, 13, 1);
        for (int i = 0; i < 30; i++) cyc(200, 1'b0);
        cyc(200, 1'b1);
        chk("rs_mid_symbol", 32'(bus.symbol), 32'd1);
        for (int i = 0; i < SC - 1; i++) cyc(200, 1'b0);
        chk("rs_mid_nopulse", 32'(bus.sym_valid), 32'd0);
        cyc(200, 1'b0);
        chk("rs_next_pulse",  32'(bus.sym_valid), 32'd1);
        chk("rs_next_symbol", 32'(bus.symbol),    32'd3);

        // resync at the decision point wins
        for (int i = 0; i < SC - 1; i++) cyc(141, 1'b0);
        cyc(141, 1'b1);
        chk("rs_last_nopulse", 32'(bus.sym_valid), 32'd0);
        chk("rs_last_symbol",  32'(bus.symbol),    32'd3);
        sym_const(141, 13, 1);

        // randomized symbols with noise outside the window, a random resync and an async reset
        r_at = $urandom_range(1, SC - 1);
        for (int p = 0; p < 10; p++) begin
            amp = $urandom_range(0, 128);
            for (int i = 0; i < SC; i++) begin
                if (m_cnt >= WS && m_cnt < WS + WN) begin
                    s = ($urandom_range(0, 1) == 1) ? 128 + amp : 128 - amp;
                    if (s > 255) s = 255;
                end else begin
                    s = $urandom_range(0, 255);
                end
                if (p == 4 && i == r_at) begin
                    cyc(s, 1'b1);
                end else if (p == 7 && i == 20) begin
                    rst = 1'b0;
                    #1;
                    check_zero("async_rst");
                    @(posedge clk);
                    #1;
                    check_zero("async_rst_hold");
                    rst = 1'b1;
                    model_reset();
                end else begin
                    cyc(s, 1'b0);
                end
            end
        end
        for (int i = 0; i < SC; i++) cyc(128, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/four_ask_demod.md
# four_ask_demod

Receive-side counterpart of the 4-ASK modulator. It takes a stream of 8-bit ADC samples of the amplitude-keyed carrier and measures the mean absolute carrier deviation over a fixed window inside each symbol. It slices that mean against three thresholds into a 2-bit symbol and re-serialises the symbol onto `message` at the original bit rate: 2 bits per symbol, MSB first. It sits between the ADC capture logic and the message sink, clocked by the same 50 MHz system clock as the modulator.

## Interface
- `SYM_CYCLES`, 50000, clocks per symbol (2 bits at 2 kHz bit rate, 50 MHz clock); must be even
- `WIN_LOG2`, 14, integration window length = 2^WIN_LOG2 clocks
- `WIN_START`, 16808, `sym_cnt` value at which the window opens; WIN_START + 2^WIN_LOG2 <= SYM_CYCLES-1
- `TH1`, 13, mean-deviation threshold for symbol 01
- `TH2`, 40, mean-deviation threshold for symbol 10
- `TH3`, 67, mean-deviation threshold for symbol 11; TH1 < TH2 < TH3
- `clk`  in  1  system clock, 50 MHz, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `sample`  in  8  unsigned ADC sample, midscale 128, one per clock
- `resync`  in  1  synchronous strobe; restarts symbol timing
- `message`  out  1  recovered serial bit stream
- `msg_valid`  out  1  high once the first symbol has been decided
- `symbol`  out  2  last decided symbol
- `sym_valid`  out  1  one-clock pulse when `symbol` updates
- `level`  out  8  last window mean deviation, for debug/threshold tuning

## Operation
- `sym_cnt` is a free-running counter from 0 to SYM_CYCLES-1 that wraps to 0.
- Deviation: dev = sample-128 when sample >= 128, else 128-sample. Range is 0..128, 8 bits.
- Accumulator width: WIN_LOG2+8 bits. It cannot overflow.
- States: WAIT, INTEG, DECIDE. WAIT is the idle state.
  - WAIT: no accumulation. When sym_cnt == WIN_START, the accumulator loads dev, not acc+dev, and the state moves to INTEG.
  - INTEG: acc += dev each clock. After exactly 2^WIN_LOG2 samples (including the loading sample), the state moves to DECIDE.
  - DECIDE: hold acc. At sym_cnt == SYM_CYCLES-1:
    - mean = acc >> WIN_LOG2.
    - symbol = 11 if mean >= TH3; else 10 if mean >= TH2; else 01 if mean >= TH1; else 00.
    - `level` <= mean.
    - `sym_valid` pulses.
    - `msg_valid` <= 1.
    - Return to WAIT.
- Serialiser: `message` = symbol[1] while sym_cnt is 0..SYM_CYCLES/2-1, and symbol[0] while sym_cnt is SYM_CYCLES/2..SYM_CYCLES-1. It always uses the registered `symbol`.
- `resync`:
  - sym_cnt <= 0, state <= WAIT, acc <= 0.
  - `symbol`, `level`, and `msg_valid` are untouched.
  - `message` continues from the restarted counter, so it is MSB for the next SYM_CYCLES/2 clocks.
- `resync` in the same cycle as the decision point: `resync` wins. No decision is made, no `sym_valid` pulse occurs, and `symbol` keeps its old value.
- `resync` during INTEG: the partial sum is discarded.

## Timing
- Reset values (asynchronously on rst = 0): sym_cnt 0, state WAIT, acc 0, `message` 0, `msg_valid` 0, `symbol` 00, `sym_valid` 0, `level` 0.
- First edge after release: sym_cnt counts 0 -> 1.
- Decision registers on the edge where sym_cnt wraps from SYM_CYCLES-1 to 0. `symbol`, `level`, and `sym_valid` are visible in the sym_cnt == 0 cycle. `sym_valid` is high for exactly that cycle.
- `message` is registered. It changes on the edges where sym_cnt becomes 0 and SYM_CYCLES/2.
- Latency: a symbol received in symbol period N appears on `message` during period N+1. That is one symbol plus one clock from the end of the window period.
- The sample taken at sym_cnt == WIN_START is the first sample counted. The sample at WIN_START + 2^WIN_LOG2 - 1 is the last.
- Samples outside the window have no effect.

## Test plan
Scenarios 1–5 use SYM_CYCLES=64, WIN_LOG2=5, WIN_START=16, with default thresholds.
1. Reset held low for 3 clocks, then released: all outputs 0. The first `sym_valid` pulse occurs in the cycle where sym_cnt returns to 0 after 64 clocks.
2. Constant samples 128, 141, 168, 200 in four consecutive symbols (mean 0, 13, 40, 72) -> `symbol` 00, 01, 10, 11. `level` 0, 13, 40, 72. `message` sequence 0,0,0,1,1,0,1,1, each bit held 32 clocks.
3. Boundary values:
   - samples 140 -> level 12, symbol 00
   - samples 195 -> level 67, symbol 11
   - samples 0 -> level 128, symbol 11
   - samples 255 -> level 127, symbol 11
4. Alternating samples 128±54 (sign flips each clock) -> mean 54, symbol 10. Glitch samples of 255 driven only outside the window (sym_cnt 0..15 and 48..63) do not change the result.
5. `resync` mid-window (sym_cnt 30): no `sym_valid` in that period, and `symbol` is retained. The next decision comes 64 clocks after `resync`. `resync` asserted exactly at sym_cnt 63: no pulse.
6. Default parameters with modulator output looped through an ADC model, driving the 128-bit message pattern at 2 kHz -> the recovered `message` matches the pattern delayed by one symbol (50000 clocks). `rst` pulsed low mid-run: outputs clear immediately, and recovery resumes.
